bit_mem_arbiter: RTL and testbench

- Controller sitting in front of a single-port 32x1 bit memory: write-enable, 5-bit address, 1-bit write data, combinational 1-bit read.
- After reset, and again on request, it sequences an initialisation sweep that writes INIT_VAL to every bit.
- It then shares the memory between two requesters with valid/ready handshakes, round-robin arbitration, and a registered read response per requester.

---
 rtl/bit_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_bit_mem_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bit_mem_arbiter
// Brief    : Init sweep plus two-requester round-robin front end for a
//            single-port 32x1 bit memory with registered read responses.
// Revision : 1.0 - initial release
// ============================================================================
module bit_mem_arbiter #(
    parameter int   ADDR_W   = 5,
    parameter logic INIT_VAL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  init_done,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [1:0]            req_wdata,
    output logic [1:0]            rsp_valid,
    output logic                  rsp_rdata,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wdata,
    input  logic                  mem_rdata
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_CNT_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic                rsp_rdata_q, rsp_rdata_d;

    logic [1:0]          w_gnt;
    logic                w_sel;
    logic [ADDR_W-1:0]   w_sel_addr;

    // Grant is only offered in RUN and never in a clear_req cycle.
    always_comb begin
        w_gnt = 2'b00;
        if (state_q == ST_RUN && !clear_req) begin
            case (req_valid)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = last_q ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign w_sel      = w_gnt[1];
    assign w_sel_addr = w_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = INIT_VAL;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == C_CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (|w_gnt) begin
                    mem_we    = req_write[w_sel];
                    mem_addr  = w_sel_addr;
                    mem_wdata = req_wdata[w_sel];
                    last_d    = w_sel;
                    if (!req_write[w_sel]) begin
                        rsp_valid_d[w_sel] = 1'b1;
                        rsp_rdata_d        = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign init_done = (state_q == ST_RUN);
    assign req_ready = w_gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_mem_arbiter
// Brief    : Self-checking bench for bit_mem_arbiter with a 32x1 memory and a
//            rule-level reference model of grants, memory and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_mem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic                clk       = 1'b0;
    logic                rst       = 1'b1;
    logic                clear_req = 1'b0;
    logic [1:0]          req_valid = 2'b00;
    logic [1:0]          req_write = 2'b00;
    logic [2*ADDR_W-1:0] req_addr  = '0;
    logic [1:0]          req_wdata = 2'b00;
    logic                init_done;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic                rsp_rdata;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wdata;
    logic                mem_rdata;

    logic mem [DEPTH];
    logic fill_ones = 1'b1;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic       ref_mem [DEPTH];
    logic       ref_last;
    logic [1:0] exp_rsp;
    logic       exp_rdata;

    bit_mem_arbiter #(.ADDR_W(ADDR_W), .INIT_VAL(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .init_done (init_done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory starts all-ones so the sweep has something to clear.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (fill_ones) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic v, input logic w,
                           input int a, input logic d);
        req_valid[r]                  = v;
        req_write[r]                  = w;
        req_addr[r*ADDR_W +: ADDR_W]  = ADDR_W'(a);
        req_wdata[r]                  = d;
    endtask

    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic model_clear_mem;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        fill_ones = 1'b0;
        checks++;
        if ({init_done, req_ready, rsp_valid, rsp_rdata} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got done=%b ready=%b rsp_v=%b rdata=%b, need all 0",
                     init_done, req_ready, rsp_valid, rsp_rdata);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            smp();
            checks++;
            if ({mem_we, mem_addr, mem_wdata, init_done, req_ready} !==
                {1'b1, ADDR_W'(k), 1'b0, 1'b0, 2'b00}) begin
                failures++;
                $display("FAIL init_sweep[%0d]: got we=%b addr=%0d wd=%b done=%b ready=%b, need we=1 addr=%0d wd=0 done=0 ready=00",
                         k, mem_we, mem_addr, mem_wdata, init_done, req_ready, k);
            end
            tick();
        end
        smp();
        checks++;
        if ({init_done, mem_we} !== 2'b10) begin
            failures++;
            $display("FAIL init_end: got done=%b we=%b, need done=1 we=0", init_done, mem_we);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (mem[i] !== 1'b0) begin
                failures++;
                $display("FAIL init_mem[%0d]: got %b, need 0", i, mem[i]);
            end
        end
        model_clear_mem();
        ref_last  = 1'b1;
        exp_rsp   = 2'b00;
        exp_rdata = 1'b0;
        tick();
    endtask

    task automatic test_write_read;
        set_req(0, 1'b1, 1'b1, 5, 1'b1);
        smp();
        checks++;
        if ({req_ready, mem_we, mem_addr, mem_wdata} !== {2'b01, 1'b1, 5'd5, 1'b1}) begin
            failures++;
            $display("FAIL wr_grant: got ready=%b we=%b addr=%0d wd=%b, need 01 1 5 1",
                     req_ready, mem_we, mem_addr, mem_wdata);
        end
        tick();
        ref_mem[5] = 1'b1;
        set_req(0, 1'b1, 1'b0, 5, 1'b0);
        smp();
        checks++;
        if ({req_ready, mem_we, mem_addr, rsp_valid} !== {2'b01, 1'b0, 5'd5, 2'b00}) begin
            failures++;
            $display("FAIL rd_grant: got ready=%b we=%b addr=%0d rsp_v=%b, need 01 0 5 00",
                     req_ready, mem_we, mem_addr, rsp_valid);
        end
        tick();
        req_valid = 2'b00;
        smp();
        checks++;
        if ({rsp_valid, rsp_rdata} !== {2'b01, 1'b1}) begin
            failures++;
            $display("FAIL rd_rsp: got rsp_v=%b rdata=%b, need 01 1", rsp_valid, rsp_rdata);
        end
        tick();
        smp();
        checks++;
        if ({rsp_valid, rsp_rdata} !== {2'b00, 1'b1}) begin
            failures++;
            $display("FAIL rd_rsp_hold: got rsp_v=%b rdata=%b, need 00 1", rsp_valid, rsp_rdata);
        end
        tick();
        ref_last  = 1'b0;
        exp_rdata = 1'b1;
    endtask

    task automatic test_round_robin;
        logic [1:0] g;
        set_req(0, 1'b1, 1'b1, 3, 1'b0);
        req_valid[1] = 1'b0;
        tick();
        ref_mem[3] = 1'b0;
        set_req(1, 1'b1, 1'b1, 7, 1'b1);
        req_valid[0] = 1'b0;
        tick();
        ref_mem[7] = 1'b1;
        ref_last   = 1'b1;
        exp_rsp    = 2'b00;
        set_req(0, 1'b1, 1'b0, 3, 1'b0);
        set_req(1, 1'b1, 1'b0, 7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            g = model_grant(2'b11, ref_last);
            smp();
            checks++;
            if (req_ready !== g) begin
                failures++;
                $display("FAIL rr_ready[%0d]: got %b, need %b", i, req_ready, g);
            end
            checks++;
            if (rsp_valid !== exp_rsp || (exp_rsp != 2'b00 && rsp_rdata !== exp_rdata)) begin
                failures++;
                $display("FAIL rr_rsp[%0d]: got rsp_v=%b rdata=%b, need %b %b",
                         i, rsp_valid, rsp_rdata, exp_rsp, exp_rdata);
            end
            tick();
            exp_rsp   = g;
            exp_rdata = g[1] ? ref_mem[7] : ref_mem[3];
            ref_last  = g[1];
        end
        req_valid = 2'b00;
        smp();
        checks++;
        if ({rsp_valid, rsp_rdata} !== {exp_rsp, exp_rdata}) begin
            failures++;
            $display("FAIL rr_rsp_last: got rsp_v=%b rdata=%b, need %b %b",
                     rsp_valid, rsp_rdata, exp_rsp, exp_rdata);
        end
        tick();
        exp_rsp = 2'b00;
    endtask

    task automatic test_same_cycle;
        set_req(0, 1'b1, 1'b1, 9, 1'b1);
        set_req(1, 1'b1, 1'b0, 9, 1'b0);
        smp();
        checks++;
        if ({req_ready, mem_we, mem_addr, mem_wdata} !== {2'b01, 1'b1, 5'd9, 1'b1}) begin
            failures++;
            $display("FAIL tie_first: got ready=%b we=%b addr=%0d wd=%b, need 01 1 9 1",
                     req_ready, mem_we, mem_addr, mem_wdata);
        end
        tick();
        ref_mem[9]   = 1'b1;
        req_valid[0] = 1'b0;
        smp();
        checks++;
        if ({req_ready, mem_we, mem_addr} !== {2'b10, 1'b0, 5'd9}) begin
            failures++;
            $display("FAIL tie_second: got ready=%b we=%b addr=%0d, need 10 0 9",
                     req_ready, mem_we, mem_addr);
        end
        tick();
        req_valid = 2'b00;
        smp();
        checks++;
        if ({rsp_valid, rsp_rdata} !== {2'b10, 1'b1}) begin
            failures++;
            $display("FAIL tie_rsp: got rsp_v=%b rdata=%b, need 10 1", rsp_valid, rsp_rdata);
        end
        tick();
        ref_last  = 1'b1;
        exp_rdata = 1'b1;
    endtask

    task automatic test_clear;
        req_valid[1] = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            set_req(0, 1'b1, 1'b1, a, 1'b1);
            tick();
            ref_mem[a] = 1'b1;
        end
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, 0, 1'b0);
        tick();
        set_req(0, 1'b1, 1'b0, 4, 1'b0);
        clear_req = 1'b1;
        smp();
        checks++;
        if ({req_ready, mem_we, init_done, rsp_valid, rsp_rdata} !==
            {2'b00, 1'b0, 1'b1, 2'b10, 1'b1}) begin
            failures++;
            $display("FAIL clear_pulse: got ready=%b we=%b done=%b rsp_v=%b rdata=%b, need 00 0 1 10 1",
                     req_ready, mem_we, init_done, rsp_valid, rsp_rdata);
        end
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            smp();
            checks++;
            if ({init_done, req_ready, mem_we, mem_addr, rsp_valid} !==
                {1'b0, 2'b00, 1'b1, ADDR_W'(k), 2'b00}) begin
                failures++;
                $display("FAIL clear_sweep[%0d]: got done=%b ready=%b we=%b addr=%0d rsp_v=%b, need 0 00 1 %0d 00",
                         k, init_done, req_ready, mem_we, mem_addr, rsp_valid, k);
            end
            tick();
        end
        req_valid = 2'b00;
        smp();
        checks++;
        if ({init_done, req_ready} !== 3'b100) begin
            failures++;
            $display("FAIL clear_done: got done=%b ready=%b, need 1 00", init_done, req_ready);
        end
        tick();
        model_clear_mem();
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) set_req(1, 1'b1, 1'b0, i, 1'b0);
            else req_valid = 2'b00;
            smp();
            if (i > 0) begin
                checks++;
                if ({rsp_valid, rsp_rdata} !== {2'b10, ref_mem[i-1]}) begin
                    failures++;
                    $display("FAIL clear_readback[%0d]: got rsp_v=%b rdata=%b, need 10 %b",
                             i-1, rsp_valid, rsp_rdata, ref_mem[i-1]);
                end
            end
            tick();
        end
        ref_last  = 1'b1;
        exp_rdata = 1'b0;
        exp_rsp   = 2'b00;
    endtask

    task automatic test_async_reset;
        set_req(0, 1'b1, 1'b1, 9, 1'b1);
        req_valid[1] = 1'b0;
        tick();
        set_req(0, 1'b1, 1'b0, 9, 1'b0);
        smp();
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL arst_grant: got ready=%b, need 01", req_ready);
        end
        @(posedge clk);
        #2;
        checks++;
        if ({rsp_valid, rsp_rdata} !== {2'b01, 1'b1}) begin
            failures++;
            $display("FAIL arst_pre: got rsp_v=%b rdata=%b, need 01 1", rsp_valid, rsp_rdata);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_rdata, init_done, req_ready} !== 5'b0) begin
            failures++;
            $display("FAIL arst_async: got rsp_v=%b rdata=%b done=%b ready=%b, need all 0",
                     rsp_valid, rsp_rdata, init_done, req_ready);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 2'b00;
        for (int k = 0; k < DEPTH; k++) begin
            smp();
            checks++;
            if ({mem_we, mem_addr, init_done} !== {1'b1, ADDR_W'(k), 1'b0}) begin
                failures++;
                $display("FAIL arst_sweep[%0d]: got we=%b addr=%0d done=%b, need 1 %0d 0",
                         k, mem_we, mem_addr, init_done, k);
            end
            tick();
        end
        smp();
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL arst_done: got done=%b, need 1", init_done);
        end
        tick();
        model_clear_mem();
        ref_last  = 1'b1;
        exp_rsp   = 2'b00;
        exp_rdata = 1'b0;
    endtask

    task automatic test_random;
        logic [1:0] g;
        logic       sel;
        int         a [2];
        logic       w [2];
        logic       d [2];
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                a[r] = int'($urandom_range(0, DEPTH-1));
                w[r] = 1'($urandom_range(0, 1));
                d[r] = 1'($urandom_range(0, 1));
                set_req(r, 1'($urandom_range(0, 1)), w[r], a[r], d[r]);
            end
            g   = model_grant(req_valid, ref_last);
            sel = g[1];
            smp();
            checks++;
            if (req_ready !== g) begin
                failures++;
                $display("FAIL rnd_ready[%0d]: got %b, need %b", n, req_ready, g);
            end
            checks++;
            if (g != 2'b00) begin
                if ({mem_we, mem_addr, mem_wdata} !== {w[sel], ADDR_W'(a[sel]), d[sel]}) begin
                    failures++;
                    $display("FAIL rnd_mem[%0d]: got we=%b addr=%0d wd=%b, need %b %0d %b",
                             n, mem_we, mem_addr, mem_wdata, w[sel], a[sel], d[sel]);
                end
            end else if ({mem_we, mem_addr, mem_wdata} !== 7'b0) begin
                failures++;
                $display("FAIL rnd_mem_idle[%0d]: got we=%b addr=%0d wd=%b, need 0 0 0",
                         n, mem_we, mem_addr, mem_wdata);
            end
            checks++;
            if ({rsp_valid, rsp_rdata} !== {exp_rsp, exp_rdata}) begin
                failures++;
                $display("FAIL rnd_rsp[%0d]: got rsp_v=%b rdata=%b, need %b %b",
                         n, rsp_valid, rsp_rdata, exp_rsp, exp_rdata);
            end
            tick();
            exp_rsp = 2'b00;
            if (g != 2'b00) begin
                ref_last = sel;
                if (w[sel]) begin
                    ref_mem[a[sel]] = d[sel];
                end else begin
                    exp_rsp   = g;
                    exp_rdata = ref_mem[a[sel]];
                end
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_same_cycle();
        test_clear();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
